image_fetch: RTL and testbench



---
 rtl/image_pkg.sv | 17 +
 rtl/image_fetch_if.sv | 23 ++
 rtl/image_scroll_ctrl.sv | 37 +++
 rtl/image_fetch.sv | 130 +++++++++++++
 tb/tb_image_fetch.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/image_pkg.sv
// Shared constants and types for the image fetch datapath.
package image_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int IMG_W     = 320;
    localparam int IMG_H     = 240;
    localparam int PIX_W     = 12;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [9:0]       coord_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/image_fetch_if.sv
// Read port of the image SRAM: the fetch unit is master, the SRAM is slave.
interface image_fetch_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 12
);

    logic                  sram_en;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data;

    modport master (
        output sram_en,
        output sram_addr,
        input  sram_data
    );

    modport slave (
        input  sram_en,
        input  sram_addr,
        output sram_data
    );

endinterface

// File: rtl/image_scroll_ctrl.sv
// Horizontal scroll offset: advances one pixel every SCROLL_DIV frame ticks, wrapping at IMG_W.
module image_scroll_ctrl
    import image_pkg::*;
#(
    parameter int IMG_W      = 320,
    parameter int SCROLL_DIV = 4,
    parameter int OFS_W      = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    output logic [OFS_W-1:0] offset
);

    localparam int CNT_W = clog2_min1(SCROLL_DIV);

    logic [CNT_W-1:0] frame_cnt;
    logic             step;

    assign step = (frame_cnt == CNT_W'(SCROLL_DIV - 1));

    // Offset only moves on frame_tick, which arrives during vertical blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (frame_tick) begin
            if (step) begin
                frame_cnt <= '0;
                offset    <= (offset == OFS_W'(IMG_W - 1)) ? '0 : offset + OFS_W'(1);
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/image_fetch.sv
// Raster-to-SRAM fetch with 2x scaling and horizontal scroll; 3-clk fixed latency to rgb.
// Optional chroma key replacement enabled by IMAGE_FETCH_CHROMA_KEY_EN.
module image_fetch
    import image_pkg::*;
#(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    IMG_W      = 320,
    parameter int                    IMG_H      = 240,
    parameter int                    SCROLL_DIV = 4,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'h0F0,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR   = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  video_on,
    input  coord_t                pixel_x,
    input  coord_t                pixel_y,
    input  logic                  hsync_i,
    input  logic                  vsync_i,
    input  logic                  frame_tick,
    image_fetch_if.master         sram,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  hsync_o,
    output logic                  vsync_o
);

    localparam int OFS_W = clog2_min1(IMG_W);

    logic [OFS_W-1:0]      offset;
    logic [10:0]           col_sum_p0;
    logic [10:0]           col_p0;
    logic [9:0]            row_p0;
    logic                  in_rng_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;

    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  vld_p1;
    logic                  hs_p1;
    logic                  vs_p1;

    logic                  vld_p2;
    logic                  hs_p2;
    logic                  vs_p2;

    logic                  unused_bits;

    function automatic logic [DATA_WIDTH-1:0] out_pixel(input logic vld,
                                                        input logic [DATA_WIDTH-1:0] d);
        if (!vld) return '0;
`ifdef IMAGE_FETCH_CHROMA_KEY_EN
        if (d == KEY_COLOR) return BG_COLOR;
`endif
        return d;
    endfunction

`ifdef IMAGE_FETCH_CHROMA_KEY_EN
    assign unused_bits = ^{pixel_x[0], pixel_y[0]};
`else
    assign unused_bits = ^{pixel_x[0], pixel_y[0], KEY_COLOR, BG_COLOR};
`endif

    image_scroll_ctrl #(
        .IMG_W      (IMG_W),
        .SCROLL_DIV (SCROLL_DIV),
        .OFS_W      (OFS_W)
    ) u_scroll (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .offset     (offset)
    );

    // Stage 0: scaled, scrolled source coordinates. offset < IMG_W, so one subtract wraps.
    always_comb begin
        col_sum_p0 = {2'b00, pixel_x[9:1]} + 11'(offset);
        col_p0     = (col_sum_p0 >= 11'(IMG_W)) ? col_sum_p0 - 11'(IMG_W) : col_sum_p0;
        row_p0     = {1'b0, pixel_y[9:1]};
        in_rng_p0  = ({1'b0, pixel_x[9:1]} < 10'(IMG_W)) && (row_p0 < 10'(IMG_H));
        addr_p0    = '0;
        if (in_rng_p0) begin
            addr_p0 = ADDR_WIDTH'(row_p0) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(col_p0);
        end
    end

    // Stage 1: SRAM address/enable and first delay stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_p1 <= '0;
            vld_p1  <= 1'b0;
            hs_p1   <= 1'b1;
            vs_p1   <= 1'b1;
        end else begin
            addr_p1 <= addr_p0;
            vld_p1  <= video_on && in_rng_p0;
            hs_p1   <= hsync_i;
            vs_p1   <= vsync_i;
        end
    end

    assign sram.sram_addr = addr_p1;
    assign sram.sram_en   = vld_p1;

    // Stage 2: SRAM read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2 <= 1'b0;
            hs_p2  <= 1'b1;
            vs_p2  <= 1'b1;
        end else begin
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
        end
    end

    // Stage 3: registered pixel and syncs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb     <= '0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else begin
            rgb     <= out_pixel(vld_p2, sram.sram_data);
            hsync_o <= hs_p2;
            vsync_o <= vs_p2;
        end
    end

endmodule

// File: tb/tb_image_fetch.sv
// Randomised and directed bench for image_fetch against a coordinate-level reference model.
module tb_image_fetch;
    import image_pkg::*;

    localparam int SCROLL_DIV = 4;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        hsync_i;
    logic        vsync_i;
    logic        frame_tick;
    logic [11:0] rgb;
    logic        hsync_o;
    logic        vsync_o;

    int   n_asserts;
    int   n_fails;
    int   ticks;
    exp_t exp_q[$];

    image_fetch_if #(.ADDR_WIDTH(17), .DATA_WIDTH(12)) sram_if ();

    image_fetch #(.SCROLL_DIV(SCROLL_DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .frame_tick (frame_tick),
        .sram       (sram_if.master),
        .rgb        (rgb),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read returning the low address bits as pixel data.
    initial sram_if.sram_data = '0;
    always @(posedge clk) sram_if.sram_data <= sram_if.sram_addr[11:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_addr(input int px, input int py, input int ofs);
        if (px / 2 >= IMG_W || py / 2 >= IMG_H) return 0;
        return (py / 2) * IMG_W + ((px / 2 + ofs) % IMG_W);
    endfunction

    function automatic logic [11:0] model_pixel(input int addr);
        logic [11:0] d;
        d = addr[11:0];
`ifdef IMAGE_FETCH_CHROMA_KEY_EN
        if (d == 12'h0F0) d = 12'h000;
`endif
        return d;
    endfunction

    task automatic model_reset();
        exp_t e;
        ticks = 0;
        exp_q.delete();
        e.rgb = 12'h000;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic vo, input int px, input int py,
                         input logic hs, input logic vs, input logic ft);
        exp_t e;
        int   a;
        logic v;
        video_on   = vo;
        pixel_x    = 10'(px);
        pixel_y    = 10'(py);
        hsync_i    = hs;
        vsync_i    = vs;
        frame_tick = ft;
        a = model_addr(px, py, (ticks / SCROLL_DIV) % IMG_W);
        v = vo && (px / 2 < IMG_W) && (py / 2 < IMG_H);
        e.rgb = v ? model_pixel(a) : 12'h000;
        e.hs  = hs;
        e.vs  = vs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("sram_addr", 32'(sram_if.sram_addr), 32'(a));
        chk("sram_en", 32'(sram_if.sram_en), 32'(v));
        e = exp_q.pop_front();
        chk("rgb", 32'(rgb), 32'(e.rgb));
        chk("hsync_o", 32'(hsync_o), 32'(e.hs));
        chk("vsync_o", 32'(vsync_o), 32'(e.vs));
        if (ft) ticks++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rgb"}, 32'(rgb), 32'h0);
        chk({tag, "_en"}, 32'(sram_if.sram_en), 32'h0);
        chk({tag, "_addr"}, 32'(sram_if.sram_addr), 32'h0);
        chk({tag, "_hs"}, 32'(hsync_o), 32'h1);
        chk({tag, "_vs"}, 32'(vsync_o), 32'h1);
    endtask

    initial begin
        n_asserts  = 0;
        n_fails    = 0;
        reset_n    = 1'b0;
        video_on   = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        hsync_i    = 1'b1;
        vsync_i    = 1'b1;
        frame_tick = 1'b0;

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            video_on   = 1'($urandom);
            pixel_x    = 10'($urandom_range(0, 639));
            pixel_y    = 10'($urandom_range(0, 479));
            hsync_i    = 1'($urandom);
            vsync_i    = 1'($urandom);
            frame_tick = 1'($urandom);
            @(posedge clk);
            #1;
            chk_reset_outputs("reset_hold");
        end

        reset_n = 1'b1;
        model_reset();

        // Scaling and address corners.
        cycle(1'b1, 5, 7, 1'b1, 1'b1, 1'b0);
        chk("addr_5_7", 32'(sram_if.sram_addr), 32'd962);
        cycle(1'b1, 639, 479, 1'b1, 1'b1, 1'b0);
        chk("addr_639_479", 32'(sram_if.sram_addr), 32'd76799);

        // Key colour and neighbour: addresses 240 (0x0F0) and 241 (0x0F1).
        cycle(1'b1, 480, 0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 482, 0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 700, 0, 1'b1, 1'b1, 1'b0);
`ifdef IMAGE_FETCH_CHROMA_KEY_EN
        chk("chroma_key", 32'(rgb), 32'h000);
`else
        chk("chroma_pass", 32'(rgb), 32'h0F0);
`endif
        cycle(1'b0, 701, 0, 1'b1, 1'b1, 1'b0);
        chk("chroma_near", 32'(rgb), 32'h0F1);

        // One full line with blanking and an hsync pulse.
        for (int x = 0; x < 800; x++) begin
            cycle(x < 640, x, 20, !(x >= 656 && x < 752), 1'b1, 1'b0);
        end

        // Eight frame ticks advance the offset by two.
        for (int i = 0; i < 8; i++) cycle(1'b0, 700, 500, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("scroll_8_ticks", 32'(sram_if.sram_addr), 32'd2);

        // Scroll to offset 319 and check the column wrap.
        for (int i = 0; i < 319 * SCROLL_DIV - 8; i++) begin
            cycle(1'($urandom), $urandom_range(0, 799), $urandom_range(0, 524),
                  1'($urandom), 1'($urandom), 1'b1);
        end
        cycle(1'b1, 2, 0, 1'b1, 1'b1, 1'b0);
        chk("scroll_wrap_col", 32'(sram_if.sram_addr), 32'd0);
        for (int i = 0; i < SCROLL_DIV; i++) cycle(1'b0, 700, 500, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 2, 0, 1'b1, 1'b1, 1'b0);
        chk("scroll_wrap_ofs", 32'(sram_if.sram_addr), 32'd1);

        // Random raster traffic with occasional frame ticks and illegal coordinates.
        for (int i = 0; i < 1500; i++) begin
            int px;
            int py;
            logic vo;
            if ($urandom_range(0, 7) == 0) begin
                px = $urandom_range(0, 1023);
                py = $urandom_range(0, 1023);
                vo = 1'($urandom);
            end else begin
                px = $urandom_range(0, 799);
                py = $urandom_range(0, 524);
                vo = (px < 640) && (py < 480);
            end
            cycle(vo, px, py, 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        end

        // Reset asserted mid-line, between clock edges.
        for (int x = 290; x <= 300; x++) cycle(1'b1, x, 10, 1'b1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        cycle(1'b1, 302, 10, 1'b1, 1'b1, 1'b0);
        chk("post_reset_addr", 32'(sram_if.sram_addr), 32'd1751);
        for (int x = 304; x < 640; x += 2) cycle(1'b1, x, 10, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 650, 10, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
